proton_fetch_queue: RTL and testbench
=====================================

PROTON_FETCH_QUEUE -- requirements
Module: proton_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning fetch-queue entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 CLK1  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 IMEM_REQ  output  1  instruction-memory read request.
REQ-006 IMEM_ADDR  output  32  byte address of request, bits [1:0] always 0.
REQ-007 IMEM_RDATA  input  32  instruction word, valid exactly one cycle after the cycle IMEM_REQ=1.
REQ-008 REDIRECT  input  1  branch/jump redirect strobe from execute.
REQ-009 REDIRECT_PC  input  32  redirect target; bits [1:0] ignored.
REQ-010 ID_VALID  output  1  queue head holds a valid instruction for decode.
REQ-011 ID_READY  input  1  decode accepts head this cycle.
REQ-012 ID_INSTR  output  32  head instruction word.
REQ-013 ID_PC  output  32  head instruction address.
REQ-014 HALTED  output  1  EBREAK (32'h0010_0073) has been handed to decode.

Function
REQ-015 Fetch PC register SHALL drive IMEM_ADDR; it advances by 4 on every issued request, wrapping 32'hFFFF_FFFC -> 0.
REQ-016 IMEM_REQ SHALL be 1 when (count + inflight - deq) < DEPTH, not halt_pending, not HALTED, REDIRECT=0; deq = ID_VALID & ID_READY.
REQ-017 A response SHALL be written at the tail as {PC of its request, IMEM_RDATA} at the edge ending the response cycle, unless discarded.
REQ-018 ID_VALID/ID_INSTR/ID_PC SHALL be registered queue-head outputs; minimum request-to-ID_VALID latency is 2 cycles.
REQ-019 Head SHALL be popped only on ID_VALID & ID_READY; ID_INSTR/ID_PC SHALL hold stable while ID_VALID=1 and ID_READY=0.
REQ-020 Enqueue and dequeue in the same cycle SHALL both occur, including when full; count unchanged.
REQ-021 Head/tail pointers SHALL wrap modulo DEPTH; queue SHALL never overflow or underflow.
REQ-022 REDIRECT=1: a handshake in the same cycle SHALL complete; then queue emptied, any in-flight response discarded, PC <= {REDIRECT_PC[31:2],2'b00}, halt_pending cleared; IMEM_REQ=0 that cycle; first request to target in the next cycle.
REQ-023 When an enqueued word equals 32'h0010_0073, halt_pending SHALL set; no further requests; responses arriving later SHALL be discarded.
REQ-024 HALTED SHALL set on the cycle after EBREAK is dequeued and remain 1 until reset; REDIRECT does not clear it.
REQ-025 With HALTED=1, IMEM_REQ=0 and ID_VALID=0 permanently.

Reset
REQ-026 RST=1 at an edge SHALL set: PC=RESET_PC, queue empty, inflight=0, halt_pending=0, HALTED=0, ID_VALID=0, ID_INSTR=0, ID_PC=0; IMEM_REQ=0 while RST=1.
REQ-027 Reset mid-operation SHALL discard in-flight response and queue contents; first cycle after RST falls, IMEM_REQ=1 with IMEM_ADDR=RESET_PC.

Verification
REQ-028 Reset release, ID_READY=1, memory returns 32'h0031_00B3 at 0 and words at 4/8 -> IMEM_ADDR 0,4,8 on consecutive cycles; ID_VALID in cycle 2 with ID_PC=0, ID_INSTR=32'h0031_00B3; one instruction per cycle thereafter.
REQ-029 ID_READY=0 from reset -> exactly 4 requests (0..12), IMEM_REQ then 0, ID_PC held at 0; ID_READY=1 -> one new request per pop, order 0,4,8,12,16 preserved.
REQ-030 REDIRECT=1, REDIRECT_PC=32'h0000_0103 while 3 entries queued plus 1 in flight -> next cycle ID_VALID=0, IMEM_ADDR=32'h100; in-flight word never appears at ID.
REQ-031 Word 6 (addr 24) = 32'h0010_0073 -> requests stop after addr 24's in-flight successor is discarded; EBREAK dequeued with ID_PC=24; HALTED=1 next cycle; IMEM_REQ, ID_VALID stay 0 for 20 cycles.
REQ-032 RST=1 for one cycle with queue full -> next cycle all outputs at reset values; after release, IMEM_ADDR=0 and ID_PC sequence restarts at 0.
REQ-033 Redirect coinciding with ID handshake of PC 8 -> PC 8 consumed exactly once; next delivered ID_PC equals redirect target.

Source files
------------

// File: rtl/proton_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response, redirect strobe and
// the decode-side head-of-queue handshake.
interface proton_fetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, halted,
    input  imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, halted,
    output imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/proton_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers responses in a
// DEPTH-entry ring and presents a registered head to decode; stops at EBREAK.
module proton_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk1,
  input  logic                  rst,
  proton_fetch_queue_if.master  fq
);

  localparam int unsigned PW     = $clog2(DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] WMASK  = 32'hFFFF_FFFC;

  logic [31:0]   pc_p0;
  logic          vld_p1;
  logic [31:0]   pc_p1;
  logic          vld_p2;
  logic [31:0]   instr_p2;
  logic [31:0]   pc_p2;

  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          halt_pending;
  logic          halted;

  logic          deq;
  logic          enq;
  logic          issue;
  logic          bypass;
  logic          halted_nxt;
  logic [CW-1:0] occ;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] head_nxt;
  logic [PW-1:0] tail_nxt;
  logic [31:0]   hd_instr_nxt;
  logic [31:0]   hd_pc_nxt;

  always_comb begin
    deq   = vld_p2 & fq.id_ready;
    // a response is dropped when flushed, or when it trails an EBREAK
    enq   = vld_p1 & ~fq.redirect & ~halt_pending & ~halted;
    // slots already promised: stored entries plus the one response in flight
    occ   = count + CW'(vld_p1) - CW'(deq);
    issue = ~rst & (occ < CW'(DEPTH)) & ~halt_pending & ~halted & ~fq.redirect;
    halted_nxt = halted | (deq & (instr_p2 == EBREAK));

    if (fq.redirect) begin
      count_nxt = '0;
      head_nxt  = '0;
      tail_nxt  = '0;
    end else begin
      count_nxt = count + CW'(enq) - CW'(deq);
      head_nxt  = head + PW'(deq);
      tail_nxt  = tail + PW'(enq);
    end

    // the slot being written this cycle becomes the new head when the queue drains to it
    bypass       = enq & (tail == head_nxt);
    hd_instr_nxt = bypass ? fq.imem_rdata : q_instr[head_nxt];
    hd_pc_nxt    = bypass ? pc_p1         : q_pc[head_nxt];
  end

  // ---- p0 -> p1: fetch PC, request tracking, queue control, head output ----
  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_p0        <= RESET_PC & WMASK;
      vld_p1       <= 1'b0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      halt_pending <= 1'b0;
      halted       <= 1'b0;
      vld_p2       <= 1'b0;
      instr_p2     <= '0;
      pc_p2        <= '0;
    end else begin
      if (fq.redirect) begin
        pc_p0 <= fq.redirect_pc & WMASK;
      end else if (issue) begin
        pc_p0 <= pc_p0 + 32'd4;
      end
      vld_p1 <= issue;
      head   <= head_nxt;
      tail   <= tail_nxt;
      count  <= count_nxt;
      halted <= halted_nxt;

      if (fq.redirect) begin
        halt_pending <= 1'b0;
      end else if (enq && (fq.imem_rdata == EBREAK)) begin
        halt_pending <= 1'b1;
      end

      // ---- p2: registered head presented to decode ----
      vld_p2 <= (count_nxt != '0) & ~halted_nxt;
      if (count_nxt != '0) begin
        instr_p2 <= hd_instr_nxt;
        pc_p2    <= hd_pc_nxt;
      end
    end
  end

  // ---- p1: response capture into the ring ----
  always_ff @(posedge clk1) begin
    if (issue) begin
      pc_p1 <= pc_p0;
    end
    if (enq) begin
      q_instr[tail] <= fq.imem_rdata;
      q_pc[tail]    <= pc_p1;
    end
  end

  assign fq.imem_req  = issue;
  assign fq.imem_addr = pc_p0;
  assign fq.id_valid  = vld_p2;
  assign fq.id_instr  = instr_p2;
  assign fq.id_pc     = pc_p2;
  assign fq.halted    = halted;

endmodule

// File: tb/tb_proton_fetch_queue.sv
// Bench for proton_fetch_queue: directed scenarios plus randomized traffic,
// checked against a program-order model of fetch addresses and delivered PCs.
module tb_proton_fetch_queue;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;

  proton_fetch_queue_if bus();

  proton_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .fq   (bus)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- memory image ----
  logic [31:0] ebreak_addr = 32'hFFFF_FFFF;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == ebreak_addr) return EBREAK;
    if (a == 32'h0) return 32'h0031_00B3;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  logic        rsp_vld = 1'b0;
  logic [31:0] rsp_word = '0;
  logic [31:0] junk = '0;

  always @(posedge clk1) begin
    rsp_vld  <= bus.imem_req;
    rsp_word <= memword(bus.imem_addr);
    junk     <= $urandom;
  end

  assign bus.imem_rdata = rsp_vld ? rsp_word : junk;

  // ---- program-order reference model ----
  int          n_req = 0;
  int          n_hs = 0;
  logic [31:0] last_hs_pc = '0;

  initial begin
    logic [31:0] m_fetch, m_exp, p_pc, p_instr;
    int          m_out;
    bit          m_halt, p_hold;
    m_fetch = 0; m_exp = 0; m_out = 0; m_halt = 0; p_hold = 0; p_pc = 0; p_instr = 0;
    forever begin
      @(negedge clk1);
      if (rst) begin
        chk("rst_noreq", {31'b0, bus.imem_req}, 32'd0);
        m_fetch = 0; m_exp = 0; m_out = 0; m_halt = 0; p_hold = 0;
      end else begin
        chk("halted", {31'b0, bus.halted}, {31'b0, m_halt});
        if (m_halt) begin
          chk("halt_noreq", {31'b0, bus.imem_req}, 32'd0);
          chk("halt_novalid", {31'b0, bus.id_valid}, 32'd0);
        end
        if (p_hold) begin
          chk("hold_valid", {31'b0, bus.id_valid}, 32'd1);
          chk("hold_pc", bus.id_pc, p_pc);
          chk("hold_instr", bus.id_instr, p_instr);
        end
        if (bus.id_valid && bus.id_ready) begin
          chk("id_pc", bus.id_pc, m_exp);
          chk("id_instr", bus.id_instr, memword(m_exp));
          n_hs++;
          last_hs_pc = bus.id_pc;
          if (memword(m_exp) == EBREAK) m_halt = 1;
          m_exp += 4;
          m_out--;
        end
        if (bus.redirect) begin
          chk("redir_noreq", {31'b0, bus.imem_req}, 32'd0);
          m_fetch = bus.redirect_pc & 32'hFFFF_FFFC;
          m_exp   = m_fetch;
          m_out   = 0;
        end else if (bus.imem_req) begin
          chk("imem_addr", bus.imem_addr, m_fetch);
          m_fetch += 4;
          m_out++;
          n_req++;
          chk("occupancy", {31'b0, (m_out <= DEPTH)}, 32'd1);
        end
        p_hold  = bus.id_valid && !bus.id_ready && !bus.redirect;
        p_pc    = bus.id_pc;
        p_instr = bus.id_instr;
      end
    end
  end

  // ---- stimulus ----
  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.id_ready = rdy;
    go(2);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    bus.id_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // sequential fetch, one instruction per cycle
    do_reset(1'b1);
    #1;
    chk("t28_req0", {31'b0, bus.imem_req}, 32'd1);
    chk("t28_addr0", bus.imem_addr, 32'h0);
    chk("t28_nv0", {31'b0, bus.id_valid}, 32'd0);
    go(1); #1;
    chk("t28_addr1", bus.imem_addr, 32'h4);
    go(1); #1;
    chk("t28_addr2", bus.imem_addr, 32'h8);
    chk("t28_v2", {31'b0, bus.id_valid}, 32'd1);
    chk("t28_pc2", bus.id_pc, 32'h0);
    chk("t28_in2", bus.id_instr, 32'h0031_00B3);
    go(1); #1;
    chk("t28_pc3", bus.id_pc, 32'h4);
    go(1); #1;
    chk("t28_pc4", bus.id_pc, 32'h8);

    // backpressure fills the queue, then pops free one slot each
    do_reset(1'b0);
    n_req = 0;
    go(10); #1;
    chk("t29_nreq", n_req, 32'd4);
    chk("t29_noreq", {31'b0, bus.imem_req}, 32'd0);
    chk("t29_v", {31'b0, bus.id_valid}, 32'd1);
    chk("t29_pc", bus.id_pc, 32'h0);
    bus.id_ready = 1'b1;
    n_hs = 0;
    #1;
    chk("t29_popreq", {31'b0, bus.imem_req}, 32'd1);
    chk("t29_addr16", bus.imem_addr, 32'h10);
    go(6);
    chk("t29_nhs", n_hs, 32'd6);
    chk("t29_last", last_hs_pc, 32'h14);

    // redirect with 3 queued + 1 in flight
    do_reset(1'b0);
    go(4); #1;
    chk("t30_v", {31'b0, bus.id_valid}, 32'd1);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    #1;
    chk("t30_noreq", {31'b0, bus.imem_req}, 32'd0);
    go(1);
    bus.redirect = 1'b0;
    #1;
    chk("t30_nv", {31'b0, bus.id_valid}, 32'd0);
    chk("t30_addr", bus.imem_addr, 32'h100);
    chk("t30_req", {31'b0, bus.imem_req}, 32'd1);
    bus.id_ready = 1'b1;
    go(2); #1;
    chk("t30_v2", {31'b0, bus.id_valid}, 32'd1);
    chk("t30_pc2", bus.id_pc, 32'h100);

    // EBREAK at address 24
    do_reset(1'b1);
    ebreak_addr = 32'd24;
    n_req = 0;
    n_hs = 0;
    go(8); #1;
    chk("t31_v", {31'b0, bus.id_valid}, 32'd1);
    chk("t31_pc", bus.id_pc, 32'd24);
    chk("t31_in", bus.id_instr, EBREAK);
    chk("t31_h0", {31'b0, bus.halted}, 32'd0);
    go(1); #1;
    chk("t31_h1", {31'b0, bus.halted}, 32'd1);
    go(20);
    chk("t31_nreq", n_req, 32'd8);
    chk("t31_nhs", n_hs, 32'd7);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    go(1);
    bus.redirect = 1'b0;
    go(3); #1;
    chk("t31_hstay", {31'b0, bus.halted}, 32'd1);
    chk("t31_noreq", {31'b0, bus.imem_req}, 32'd0);

    // reset while full
    do_reset(1'b0);
    ebreak_addr = 32'hFFFF_FFFF;
    go(8);
    chk("t32_full", {31'b0, bus.id_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t32_rstreq", {31'b0, bus.imem_req}, 32'd0);
    go(1);
    rst = 1'b0;
    #1;
    chk("t32_v", {31'b0, bus.id_valid}, 32'd0);
    chk("t32_in", bus.id_instr, 32'h0);
    chk("t32_pc", bus.id_pc, 32'h0);
    chk("t32_h", {31'b0, bus.halted}, 32'd0);
    chk("t32_addr", bus.imem_addr, 32'h0);
    chk("t32_req", {31'b0, bus.imem_req}, 32'd1);
    bus.id_ready = 1'b1;
    n_hs = 0;
    go(5);
    chk("t32_nhs", n_hs, 32'd3);
    chk("t32_last", last_hs_pc, 32'h8);

    // redirect coinciding with the handshake of PC 8
    do_reset(1'b1);
    go(4); #1;
    chk("t33_pc8", bus.id_pc, 32'h8);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    n_hs = 0;
    go(1);
    bus.redirect = 1'b0;
    for (k = 0; k < 10 && !bus.id_valid; k++) go(1);
    chk("t33_timeout", {31'b0, (k < 10)}, 32'd1);
    chk("t33_tgt", bus.id_pc, 32'h200);
    chk("t33_once", n_hs, 32'd1);

    // randomized traffic, including wrap-around targets and an EBREAK at 0x400
    do_reset(1'b1);
    ebreak_addr = 32'h400;
    for (int i = 0; i < 3000; i++) begin
      go(1);
      rst = ($urandom_range(0, 199) == 0);
      bus.id_ready = ($urandom_range(0, 9) < 7);
      bus.redirect = !rst && ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0)
        bus.redirect_pc = 32'hFFFF_FFE0 | $urandom_range(0, 31);
      else
        bus.redirect_pc = $urandom_range(0, 32'h7FF);
    end
    go(1);
    rst = 1'b0;
    bus.redirect = 1'b0;
    go(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
